// File: rtl/bp_me_accel_wr_sink.sv
// bp_me_accel_wr_sink
//
// Memory-side responder for the accelerator's BedRock mem_fwd stream.
// - Uncached streamed writes (uc_wr) are absorbed into a local block scratchpad
//   and acknowledged with a single mem_rev beat that carries zero data.
// - Uncached reads (uc_rd) stream the stored beats back on mem_rev.
// - Any other msg_type is acknowledged without a write and sets the sticky error_o.
//
// The header is a flat packed vector, LSB first:
//   msg_type[3:0] | subop[3:0] | addr[paddr_width_p-1:0] | size[2:0] | payload
// msg_type encoding: uc_rd = 2, uc_wr = 3. size encoding: bytes = 1 << size.
// The processor configuration is expressed through the width parameters below.
//
// Optional feature macro: BP_ME_ACCEL_WR_SINK_COUNT_EN
//   defined   -> wr_count_o counts completed write transactions (wraps at 2^32)
//   undefined -> no counter flops, wr_count_o is tied to 0
//
// Ports
//   clk_i                clock
//   reset_i              synchronous, active-high reset
//   mem_fwd_header_i     request header, stable for all beats of a request
//   mem_fwd_data_i       request data beat
//   mem_fwd_v_i          request beat valid
//   mem_fwd_ready_and_o  request beat accepted when valid & ready
//   mem_rev_header_o     response header (echo of the request header)
//   mem_rev_data_o       response data beat
//   mem_rev_v_o          response beat valid
//   mem_rev_ready_and_i  response beat consumed when valid & ready
//   error_o              sticky: unsupported msg_type seen
//   wr_count_o           completed write transactions
module bp_me_accel_wr_sink
  #(parameter int paddr_width_p   = 40
   ,parameter int payload_width_p = 16
   ,parameter int fill_width_p    = 64
   ,parameter int els_p           = 16
   ,parameter int block_width_p   = 512
   ,localparam int mem_fwd_header_width_lp = 4 + 4 + paddr_width_p + 3 + payload_width_p
   ,localparam int mem_rev_header_width_lp = mem_fwd_header_width_lp
   )
  (input  logic                               clk_i
  ,input  logic                               reset_i
  ,input  logic [mem_fwd_header_width_lp-1:0] mem_fwd_header_i
  ,input  logic [fill_width_p-1:0]            mem_fwd_data_i
  ,input  logic                               mem_fwd_v_i
  ,output logic                               mem_fwd_ready_and_o
  ,output logic [mem_rev_header_width_lp-1:0] mem_rev_header_o
  ,output logic [fill_width_p-1:0]            mem_rev_data_o
  ,output logic                               mem_rev_v_o
  ,input  logic                               mem_rev_ready_and_i
  ,output logic                               error_o
  ,output logic [31:0]                        wr_count_o
  );

  localparam int beats_lp    = block_width_p / fill_width_p;
  localparam int beat_w_lp   = $clog2(beats_lp);
  localparam int idx_w_lp    = $clog2(els_p);
  localparam int blk_off_lp  = $clog2(block_width_p / 8);
  localparam int fill_off_lp = $clog2(fill_width_p / 8);
  localparam int addr_off_lp = 8;
  localparam int size_off_lp = addr_off_lp + paddr_width_p;

  localparam logic [3:0] msg_uc_rd_lp = 4'd2;
  localparam logic [3:0] msg_uc_wr_lp = 4'd3;

  typedef enum logic [1:0] {eREADY, eWR_DATA, eRESP, eRD_DATA} state_e;

  // Index of the last beat of a transaction: beats = max(1, bits/fill), clamped
  // to a full block for sizes larger than a block.
  function automatic logic [beat_w_lp-1:0] last_beat(input logic [2:0] size);
    int sh;
    sh = int'(size) - fill_off_lp;
    if (sh <= 0)
      return '0;
    else if (sh >= beat_w_lp)
      return beat_w_lp'(beats_lp - 1);
    else
      return beat_w_lp'((1 << sh) - 1);
  endfunction

  state_e                             state_q, state_d;
  logic [mem_fwd_header_width_lp-1:0] hdr_q, hdr_d;
  logic [beat_w_lp-1:0]               last_q, last_d;
  logic [beat_w_lp-1:0]               start_q, start_d;
  logic [beat_w_lp-1:0]               cnt_q, cnt_d;
  logic                               error_q, error_d;

  logic [fill_width_p-1:0] mem_q [els_p*beats_lp];

  logic [3:0]                    type_i, type_q;
  logic [2:0]                    size_i;
  logic [idx_w_lp-1:0]           idx_i, idx_q;
  logic [beat_w_lp-1:0]          start_i;
  logic [beat_w_lp-1:0]          beat_q;
  logic                          wr_v;
  logic [idx_w_lp+beat_w_lp-1:0] wr_addr;
  logic                          fwd_ready;
  logic                          rev_v;
  logic [fill_width_p-1:0]       rev_data;

  assign type_i  = mem_fwd_header_i[3:0];
  assign size_i  = mem_fwd_header_i[size_off_lp +: 3];
  assign idx_i   = mem_fwd_header_i[addr_off_lp+blk_off_lp +: idx_w_lp];
  assign start_i = mem_fwd_header_i[addr_off_lp+fill_off_lp +: beat_w_lp];

  assign type_q  = hdr_q[3:0];
  assign idx_q   = hdr_q[addr_off_lp+blk_off_lp +: idx_w_lp];
  // Beat position wraps naturally within the block through the narrow add.
  assign beat_q  = start_q + cnt_q;

  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    last_d    = last_q;
    start_d   = start_q;
    cnt_d     = cnt_q;
    error_d   = error_q;
    fwd_ready = 1'b0;
    rev_v     = 1'b0;
    rev_data  = '0;
    wr_v      = 1'b0;
    wr_addr   = {idx_q, beat_q};

    case (state_q)
      eREADY: begin
        fwd_ready = 1'b1;
        if (mem_fwd_v_i) begin
          hdr_d   = mem_fwd_header_i;
          last_d  = last_beat(size_i);
          start_d = start_i;
          // Beat 0 is consumed here, so the data phase resumes at beat 1.
          cnt_d   = beat_w_lp'(1);
          case (type_i)
            msg_uc_wr_lp: begin
              wr_v    = 1'b1;
              wr_addr = {idx_i, start_i};
              state_d = (last_beat(size_i) == '0) ? eRESP : eWR_DATA;
            end
            msg_uc_rd_lp: begin
              cnt_d   = '0;
              state_d = eRD_DATA;
            end
            default: begin
              error_d = 1'b1;
              state_d = eRESP;
            end
          endcase
        end
      end

      eWR_DATA: begin
        fwd_ready = 1'b1;
        if (mem_fwd_v_i) begin
          wr_v = 1'b1;
          if (cnt_q == last_q)
            state_d = eRESP;
          else
            cnt_d = cnt_q + 1'b1;
        end
      end

      eRESP: begin
        rev_v = 1'b1;
        if (mem_rev_ready_and_i)
          state_d = eREADY;
      end

      eRD_DATA: begin
        rev_v    = 1'b1;
        rev_data = mem_q[{idx_q, beat_q}];
        if (mem_rev_ready_and_i) begin
          if (cnt_q == last_q) begin
            cnt_d   = '0;
            state_d = eREADY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: state_d = eREADY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eREADY;
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      error_q <= error_d;
    end
  end

  // Transaction context is only meaningful after a header handshake, so it
  // carries no reset.
  always_ff @(posedge clk_i) begin
    hdr_q   <= hdr_d;
    last_q  <= last_d;
    start_q <= start_d;
  end

  // Scratchpad survives reset; a write lands one cycle before the ack can be
  // presented, so a following read always observes it.
  always_ff @(posedge clk_i) begin
    if (wr_v)
      mem_q[wr_addr] <= mem_fwd_data_i;
  end

`ifdef BP_ME_ACCEL_WR_SINK_COUNT_EN
  logic [31:0] wr_count_q;
  always_ff @(posedge clk_i) begin
    if (reset_i)
      wr_count_q <= '0;
    else if (state_q == eRESP && mem_rev_ready_and_i && type_q == msg_uc_wr_lp)
      wr_count_q <= wr_count_q + 32'd1;
  end
  assign wr_count_o = wr_count_q;
`else
  assign wr_count_o = '0;
`endif

  assign mem_fwd_ready_and_o = fwd_ready;
  assign mem_rev_v_o         = rev_v;
  assign mem_rev_header_o    = hdr_q;
  assign mem_rev_data_o      = rev_data;
  assign error_o             = error_q;

endmodule

// File: tb/tb_bp_me_accel_wr_sink.sv
module tb_bp_me_accel_wr_sink;

  localparam int HW = 4 + 4 + 40 + 3 + 16;
  localparam int CW = HW + 65;
  typedef logic [CW-1:0] cw_t;

`ifdef BP_ME_ACCEL_WR_SINK_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic [HW-1:0] mem_fwd_header_i = '0;
  logic [63:0]   mem_fwd_data_i = '0;
  logic          mem_fwd_v_i = 1'b0;
  logic          mem_fwd_ready_and_o;
  logic [HW-1:0] mem_rev_header_o;
  logic [63:0]   mem_rev_data_o;
  logic          mem_rev_v_o;
  logic          rev_rdy = 1'b1;
  logic          error_o;
  logic [31:0]   wr_count_o;

  bp_me_accel_wr_sink dut (
    .clk_i               (clk),
    .reset_i             (reset_i),
    .mem_fwd_header_i    (mem_fwd_header_i),
    .mem_fwd_data_i      (mem_fwd_data_i),
    .mem_fwd_v_i         (mem_fwd_v_i),
    .mem_fwd_ready_and_o (mem_fwd_ready_and_o),
    .mem_rev_header_o    (mem_rev_header_o),
    .mem_rev_data_o      (mem_rev_data_o),
    .mem_rev_v_o         (mem_rev_v_o),
    .mem_rev_ready_and_i (rev_rdy),
    .error_o             (error_o),
    .wr_count_o          (wr_count_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fwd_acc = 0;
  logic [HW+63:0] sb[$];
  logic [63:0] D[8];
  logic [63:0] blk[8];

  function automatic logic [HW-1:0] mk_hdr(input logic [3:0] t, input logic [39:0] a,
                                           input logic [2:0] s, input logic [15:0] p);
    return {p, s, a, 4'h0, t};
  endfunction

  task automatic chk(input string nm, input cw_t act, input cw_t exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Monitor: counts accepted fwd beats and checks every consumed rev beat.
  always @(negedge clk) begin
    if (!reset_i && mem_fwd_v_i && mem_fwd_ready_and_o) fwd_acc++;
    if (!reset_i && mem_rev_v_o && rev_rdy) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_rev_beat: got hdr %h data %h, want none",
                 mem_rev_header_o, mem_rev_data_o);
      end else begin
        chk("rev_beat", cw_t'({mem_rev_header_o, mem_rev_data_o}), cw_t'(sb.pop_front()));
      end
    end
  end

  task automatic send_beat(input logic [HW-1:0] h, input logic [63:0] d);
    int t;
    t = 0;
    mem_fwd_header_i = h;
    mem_fwd_data_i   = d;
    mem_fwd_v_i      = 1'b1;
    @(negedge clk);
    while (!mem_fwd_ready_and_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!mem_fwd_ready_and_o) begin
      n_chk++;
      n_fail++;
      $display("FAIL fwd_timeout: got ready 0, want 1");
    end
    @(posedge clk); #1;
    mem_fwd_v_i = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((sb.size() != 0 || !mem_fwd_ready_and_o || mem_rev_v_o) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_chk++;
      n_fail++;
      $display("FAIL idle_timeout: got %0d pending beats, want 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic read_blk(input logic [HW-1:0] h, input int start);
    for (int i = 0; i < 8; i++) sb.push_back({h, blk[(start + i) % 8]});
    send_beat(h, 64'h0);
  endtask

  logic [HW-1:0] h;

  initial begin
    for (int i = 0; i < 8; i++) begin
      D[i]   = 64'hC0DE_0000_0000_0000 + 64'(i);
      blk[i] = D[i];
    end

    // reset state
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    chk("rst_fwd_ready", cw_t'(mem_fwd_ready_and_o), cw_t'(1));
    chk("rst_rev_v", cw_t'(mem_rev_v_o), cw_t'(0));
    chk("rst_error", cw_t'(error_o), cw_t'(0));
    chk("rst_wr_count", cw_t'(wr_count_o), cw_t'(0));
    @(posedge clk); #1;

    // 1: 64B write to 0x40
    fwd_acc = 0;
    h = mk_hdr(4'd3, 40'h40, 3'd6, 16'h1111);
    sb.push_back({h, 64'h0});
    for (int i = 0; i < 8; i++) send_beat(h, D[i]);
    wait_idle();
    chk("t1_fwd_accepts", cw_t'(fwd_acc), cw_t'(8));
    chk("t1_wr_count", cw_t'(wr_count_o), cw_t'(CNT_EN ? 1 : 0));

    // 2: read it back in order
    read_blk(mk_hdr(4'd2, 40'h40, 3'd6, 16'h2222), 0);
    wait_idle();

    // 3: single 8B write to beat 3, then full read
    h = mk_hdr(4'd3, 40'h58, 3'd3, 16'h3333);
    sb.push_back({h, 64'h0});
    send_beat(h, 64'hAA);
    wait_idle();
    blk[3] = 64'hAA;
    read_blk(mk_hdr(4'd2, 40'h40, 3'd6, 16'h3334), 0);
    wait_idle();

    // 4: read starting at beat 2 wraps
    read_blk(mk_hdr(4'd2, 40'h50, 3'd6, 16'h4444), 2);
    wait_idle();

    // 5: back-pressure mid-read
    h = mk_hdr(4'd2, 40'h40, 3'd6, 16'h5555);
    read_blk(h, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rev_rdy = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_stall_hold", cw_t'({mem_rev_v_o, mem_rev_header_o, mem_rev_data_o}),
          cw_t'({1'b1, h, blk[2]}));
    end
    @(posedge clk); #1;
    rev_rdy = 1'b1;
    wait_idle();

    // 6: amo is acked, flags error, writes nothing
    h = mk_hdr(4'd5, 40'h40, 3'd3, 16'h6666);
    sb.push_back({h, 64'h0});
    send_beat(h, 64'hDEAD_BEEF);
    wait_idle();
    chk("t6_error", cw_t'(error_o), cw_t'(1));
    chk("t6_wr_count", cw_t'(wr_count_o), cw_t'(CNT_EN ? 2 : 0));
    // 128B read clamps to one block
    read_blk(mk_hdr(4'd2, 40'h40, 3'd7, 16'h6667), 0);
    wait_idle();

    // 7: reset during beat 3 of an 8-beat write
    h = mk_hdr(4'd3, 40'h80, 3'd6, 16'h7777);
    for (int i = 0; i < 3; i++) send_beat(h, 64'h7700 + 64'(i));
    reset_i = 1'b1;
    @(posedge clk); #1;
    reset_i = 1'b0;
    @(negedge clk);
    chk("t7_fwd_ready", cw_t'(mem_fwd_ready_and_o), cw_t'(1));
    chk("t7_rev_v", cw_t'(mem_rev_v_o), cw_t'(0));
    chk("t7_error", cw_t'(error_o), cw_t'(0));
    chk("t7_wr_count", cw_t'(wr_count_o), cw_t'(0));
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    read_blk(mk_hdr(4'd2, 40'h40, 3'd6, 16'h7778), 0);
    wait_idle();

    chk("sb_drained", cw_t'(sb.size()), cw_t'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_fail);
    $finish;
  end

endmodule
